// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle controller and the datapath muxes it steers.
// State codes, opcodes, ALU operand-B selects, ALU op codes and the control-word struct.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [2:0] SRCB_B        = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_SEXT     = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'd3;
  localparam logic [2:0] SRCB_ZEXT     = 3'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI: op_supported = 1'b1;
      default:                  op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_decode.sv
// Combinational control-word decode for the multi-cycle controller.
// Outputs depend on state, plus opcode/zero/mem_ready in the states that need them.
module mc_ctrl_decode
  import mc_control_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SEXT_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = ~op_supported(opcode);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        // addi sign-extends and adds; andi/ori zero-extend and let the ALU pick the logic op
        if (opcode == OP_ADDI) begin
          ctrl.alu_src_b = SRCB_SEXT;
          ctrl.alu_op    = ALUOP_ADD;
        end else begin
          ctrl.alu_src_b = SRCB_ZEXT;
          ctrl.alu_op    = ALUOP_LOGIC;
        end
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-style control FSM: state register, next-state logic and decode instance.
// Memory handshake: an access issued in FETCH/MEM_READ/MEM_WRITE completes in the cycle mem_ready=1.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:               state_d = S_R_EXEC;
          OP_LW, OP_SW:           state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:         state_d = S_BRANCH;
          OP_J:                   state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );

  // Reset forces state to FETCH, whose decode would raise mem_read; mask everything while held.
  assign ctrl = reset ? '0 : ctrl_raw;

  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign i_or_d     = ctrl.i_or_d;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign illegal    = ctrl.illegal;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class, reset cases and a random invariant run.
module tb_mc_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal    (illegal),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word: {pcw,irw,mr,mw,iod,rw,rd,m2r,asa,asb[3],aop[2],pcs[2],ill}
  function automatic logic [16:0] mk(input logic pcw, irw, mr, mw, iod, rw, rd, m2r, asa,
                                     input logic [2:0] asb, input logic [1:0] aop,
                                     input logic [1:0] pcs, input logic ill);
    mk = {pcw, irw, mr, mw, iod, rw, rd, m2r, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic [16:0] obs_word();
    obs_word = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
  endfunction

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_word);
    #1;
    check({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
    check({tag, ".ctrl"}, {15'd0, obs_word()}, {15'd0, exp_word});
  endtask

  localparam logic [16:0] W_ZERO        = 17'd0;
  localparam logic [16:0] W_FETCH_WAIT  = mk(0,0,1,0,0,0,0,0,0,3'd1,2'd0,2'd0,0);
  localparam logic [16:0] W_FETCH_GO    = mk(1,1,1,0,0,0,0,0,0,3'd1,2'd0,2'd0,0);
  localparam logic [16:0] W_DECODE      = mk(0,0,0,0,0,0,0,0,0,3'd3,2'd0,2'd0,0);
  localparam logic [16:0] W_DECODE_ILL  = mk(0,0,0,0,0,0,0,0,0,3'd3,2'd0,2'd0,1);
  localparam logic [16:0] W_MEM_ADDR    = mk(0,0,0,0,0,0,0,0,1,3'd2,2'd0,2'd0,0);
  localparam logic [16:0] W_MEM_READ    = mk(0,0,1,0,1,0,0,0,0,3'd0,2'd0,2'd0,0);
  localparam logic [16:0] W_MEM_WB      = mk(0,0,0,0,0,1,0,1,0,3'd0,2'd0,2'd0,0);
  localparam logic [16:0] W_MEM_WRITE   = mk(0,0,0,1,1,0,0,0,0,3'd0,2'd0,2'd0,0);
  localparam logic [16:0] W_R_EXEC      = mk(0,0,0,0,0,0,0,0,1,3'd0,2'd2,2'd0,0);
  localparam logic [16:0] W_R_WB        = mk(0,0,0,0,0,1,1,0,0,3'd0,2'd0,2'd0,0);
  localparam logic [16:0] W_BR_TAKEN    = mk(1,0,0,0,0,0,0,0,1,3'd0,2'd1,2'd1,0);
  localparam logic [16:0] W_BR_NOT      = mk(0,0,0,0,0,0,0,0,1,3'd0,2'd1,2'd1,0);
  localparam logic [16:0] W_JUMP        = mk(1,0,0,0,0,0,0,0,0,3'd0,2'd0,2'd2,0);
  localparam logic [16:0] W_I_EXEC_ADD  = mk(0,0,0,0,0,0,0,0,1,3'd2,2'd0,2'd0,0);
  localparam logic [16:0] W_I_EXEC_LOG  = mk(0,0,0,0,0,0,0,0,1,3'd4,2'd3,2'd0,0);
  localparam logic [16:0] W_I_WB        = mk(0,0,0,0,0,1,0,0,0,3'd0,2'd0,2'd0,0);

  initial begin
    reset     = 1'b1;
    opcode    = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #3;
    check_state("reset", 4'd0, W_ZERO);
    tick();
    check_state("reset_held", 4'd0, W_ZERO);
    reset = 1'b0;

    // FETCH stalls while memory not ready
    check_state("fetch_wait0", 4'd0, W_FETCH_WAIT);
    tick();
    check_state("fetch_wait1", 4'd0, W_FETCH_WAIT);

    // lw: 0,1,2,3,4,0
    opcode = 6'h23; mem_ready = 1'b1;
    check_state("lw.fetch", 4'd0, W_FETCH_GO);
    tick(); check_state("lw.decode", 4'd1, W_DECODE);
    tick(); check_state("lw.addr", 4'd2, W_MEM_ADDR);
    tick(); check_state("lw.read", 4'd3, W_MEM_READ);
    tick(); check_state("lw.wb", 4'd4, W_MEM_WB);
    tick(); check_state("lw.done", 4'd0, W_FETCH_GO);

    // sw with three wait cycles in MEM_WRITE
    opcode = 6'h2B;
    tick(); check_state("sw.decode", 4'd1, W_DECODE);
    tick(); check_state("sw.addr", 4'd2, W_MEM_ADDR);
    mem_ready = 1'b0;
    tick(); check_state("sw.wait1", 4'd5, W_MEM_WRITE);
    tick(); check_state("sw.wait2", 4'd5, W_MEM_WRITE);
    tick(); check_state("sw.wait3", 4'd5, W_MEM_WRITE);
    mem_ready = 1'b1;
    check_state("sw.ready", 4'd5, W_MEM_WRITE);
    tick(); check_state("sw.done", 4'd0, W_FETCH_GO);

    // R-type
    opcode = 6'h00;
    tick(); check_state("r.decode", 4'd1, W_DECODE);
    tick(); check_state("r.exec", 4'd6, W_R_EXEC);
    tick(); check_state("r.wb", 4'd7, W_R_WB);
    tick(); check_state("r.done", 4'd0, W_FETCH_GO);

    // beq: taken with zero=1, not taken with zero=0
    opcode = 6'h04; zero = 1'b1;
    tick(); check_state("beq.decode", 4'd1, W_DECODE);
    tick(); check_state("beq.z1", 4'd8, W_BR_TAKEN);
    zero = 1'b0;
    check_state("beq.z0", 4'd8, W_BR_NOT);
    tick(); check_state("beq.done", 4'd0, W_FETCH_GO);

    // bne: not taken with zero=1, taken with zero=0
    opcode = 6'h05; zero = 1'b1;
    tick(); check_state("bne.decode", 4'd1, W_DECODE);
    tick(); check_state("bne.z1", 4'd8, W_BR_NOT);
    zero = 1'b0;
    check_state("bne.z0", 4'd8, W_BR_TAKEN);
    tick(); check_state("bne.done", 4'd0, W_FETCH_GO);

    // jump
    opcode = 6'h02;
    tick(); check_state("j.decode", 4'd1, W_DECODE);
    tick(); check_state("j.jump", 4'd9, W_JUMP);
    tick(); check_state("j.done", 4'd0, W_FETCH_GO);

    // ori then addi
    opcode = 6'h0D;
    tick(); check_state("ori.decode", 4'd1, W_DECODE);
    tick(); check_state("ori.exec", 4'd10, W_I_EXEC_LOG);
    tick(); check_state("ori.wb", 4'd11, W_I_WB);
    tick(); check_state("ori.done", 4'd0, W_FETCH_GO);
    opcode = 6'h08;
    tick(); check_state("addi.decode", 4'd1, W_DECODE);
    tick(); check_state("addi.exec", 4'd10, W_I_EXEC_ADD);
    tick(); check_state("addi.wb", 4'd11, W_I_WB);
    tick(); check_state("addi.done", 4'd0, W_FETCH_GO);

    // illegal opcode: one-cycle pulse in DECODE, then FETCH
    opcode = 6'h3F;
    tick(); check_state("ill.decode", 4'd1, W_DECODE_ILL);
    tick(); check_state("ill.done", 4'd0, W_FETCH_GO);

    // asynchronous reset mid-R_EXEC
    opcode = 6'h00;
    tick(); check_state("rst.decode", 4'd1, W_DECODE);
    tick(); check_state("rst.exec", 4'd6, W_R_EXEC);
    reset = 1'b1;
    check_state("rst.async", 4'd0, W_ZERO);
    tick(); check_state("rst.held", 4'd0, W_ZERO);
    reset = 1'b0;
    check_state("rst.release", 4'd0, W_FETCH_GO);

    // reset during a MEM_READ wait
    opcode = 6'h23;
    tick(); check_state("rst2.decode", 4'd1, W_DECODE);
    tick(); check_state("rst2.addr", 4'd2, W_MEM_ADDR);
    mem_ready = 1'b0;
    tick(); check_state("rst2.wait", 4'd3, W_MEM_READ);
    reset = 1'b1;
    check_state("rst2.async", 4'd0, W_ZERO);
    tick();
    reset = 1'b0;
    check_state("rst2.release", 4'd0, W_FETCH_WAIT);

    // random run: operand-B code range and strobe mutual exclusion
    for (int i = 0; i < 300; i++) begin
      opcode    = 6'($urandom_range(0, 63));
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      #1;
      check("rand.asb_range", {31'd0, alu_src_b > 3'd4}, 32'd0);
      check("rand.mem_excl", {31'd0, mem_read & mem_write}, 32'd0);
      check("rand.wr_excl", {31'd0, pc_write & reg_write}, 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
